data_memory_access_controller: RTL and testbench
================================================

// Module: data_memory_access_controller
// PURPOSE
//  Sequences loads/stores from the pipeline MEM stage onto a valid/ready data-memory bus. Stalls the pipeline until the access completes.
//  Builds byte enables and aligned store data from the HighLevelControl::truncSrc width, and sign/zero-extends load data.
//  Splits word-crossing accesses into two word transfers, or faults them when splitting is disabled.
// PARAMETERS
//  XLEN              32  data/address width (only 32 supported)
//  SPLIT_MISALIGNED  1   1: split word-crossing accesses into 2 transfers; 0: raise MisalignFault, no bus access
// PORTS
//  clk            in   1     clock; all state updates on rising edge
//  reset          in   1     synchronous, active-high
//  MemReq         in   1     MEM stage holds a load/store; inputs stable while Stall=1
//  MemWrite       in   1     1 store, 0 load
//  TruncSrc       in   3     truncSrc: BYTE,HALF_WORD,WORD,BYTE_UNSIGNED,HALF_WORD_UNSIGNED,NO_TRUNC (=0..5)
//  Addr           in   XLEN  byte address
//  WriteData      in   XLEN  store data, LSB-justified
//  Stall          out  1     hold pipeline
//  Done           out  1     1-cycle completion pulse
//  ReadData       out  XLEN  extended load result, valid when Done
//  MisalignFault  out  1     pulses with Done on faulted access
//  BusValid       out  1     transfer request
//  BusReady       in   1     transfer accepted when BusValid&&BusReady
//  BusWrite       out  1     1 write
//  BusAddr        out  XLEN  word-aligned address, [1:0]=0
//  BusByteEn      out  4     byte lanes (reads too)
//  BusWData       out  XLEN  lane-aligned write data
//  BusRData       in   XLEN  read data, valid in accept cycle
// BEHAVIOUR
//  Size: BYTE/BYTE_UNSIGNED=1, HALF*=2, WORD/NO_TRUNC/codes 6-7=4 bytes. off=Addr[1:0].
//  Crossing when off+size>4.
//  FSM IDLE->ACCESS0->[ACCESS1]->RESP->IDLE.
//  IDLE:
//   - MemReq=1: latch request; go ACCESS0.
//   - MemReq=1, crossing, SPLIT_MISALIGNED=0: go RESP with fault flag.
//  ACCESS0: BusValid=1, BusAddr={Addr[31:2],2'b0}.
//   - Non-crossing: ByteEn = sizemask<<off; WData = WriteData<<8*off.
//   - Crossing: ByteEn = 4'b1111<<off (4 bits); WData = WriteData<<8*off.
//   - On accept: go ACCESS1 if crossing, else RESP.
//  ACCESS1: BusAddr = first+4.
//   - ByteEn = sizemask>>(4-off); WData = WriteData>>8*(4-off).
//   - On accept: go RESP.
//  Load data: raw = (rd0>>8*off) | (rd1<<8*(4-off)); rd1 term only when crossing.
//   - Raw latched at accept.
//   - Truncate to size; sign-extend for BYTE/HALF_WORD, zero-extend for *_UNSIGNED. WORD/NO_TRUNC pass through.
//  RESP:
//   - Done=1, Stall=0, ReadData valid, MisalignFault=fault flag. Go IDLE.
//   - Stores and faults give ReadData=0.
//  Stall:
//   - Combinational = (IDLE&&MemReq) | ACCESS0 | ACCESS1; 0 in RESP.
//   - An aligned, zero-wait access stalls 2 cycles. Done is in cycle 2, counting the request cycle as 0.
//   - A split access gives Done in cycle 3. Each BusReady=0 cycle adds 1.
//  Bus rule: while BusValid=1 and not accepted, BusAddr/BusWrite/BusByteEn/BusWData are held stable.
//   - BusValid never drops before accept, except on reset.
//  MemReq seen in the cycle after RESP is a new instruction.
//  Reset, any state:
//   - Next state IDLE. BusValid, Done and MisalignFault are 0. ReadData is 0.
//   - Stall is forced 0 while reset=1. An in-flight transfer is abandoned.
// TESTING
//  1. LW 0x100, BusReady=1, RData 0xDEADBEEF -> one transfer, BusAddr 0x100, ByteEn 1111; Done cycle 2, ReadData 0xDEADBEEF, Stall cycles 0-1.
//  2. LB/LBU 0x103, RData 0x80112233 -> ByteEn 1000; ReadData 0xFFFFFF80 / 0x00000080.
//  3. SH 0x102, WriteData 0x1234ABCD -> BusWrite=1, ByteEn 1100, BusWData 0xABCD0000.
//  4. LW 0x101, mem[0x100]=0x44332211, mem[0x104]=0x88776655 -> transfers 0x100 then 0x104; ReadData 0x55443322, Done cycle 3.
//  5. SW 0x103 with BusReady low 3 cycles each transfer -> ByteEn 1000 then 0111; bus signals stable while waiting; Stall held; Done cycle 9.
//  6. Reset in ACCESS1 -> BusValid 0 next cycle, no Done. SPLIT_MISALIGNED=0, LH 0x103 -> Done+MisalignFault cycle 1, BusValid never 1.

Source files
------------

// File: rtl/data_memory_access_controller.sv
// Data-memory access sequencer: turns MEM-stage loads/stores into valid/ready
// word transfers, splitting or faulting word-crossing accesses.
module data_memory_access_controller #(
  parameter int XLEN             = 32,   // only 32 is supported
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReq,
  input  logic            MemWrite,
  input  logic [2:0]      TruncSrc,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
  output logic            Stall,
  output logic            Done,
  output logic [XLEN-1:0] ReadData,
  output logic            MisalignFault,
  output logic            BusValid,
  input  logic            BusReady,
  output logic            BusWrite,
  output logic [XLEN-1:0] BusAddr,
  output logic [3:0]      BusByteEn,
  output logic [XLEN-1:0] BusWData,
  input  logic [XLEN-1:0] BusRData
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS0,
    ST_ACCESS1,
    ST_RESP
  } state_e;

  localparam logic [2:0] TR_BYTE               = 3'd0;
  localparam logic [2:0] TR_HALF_WORD          = 3'd1;
  localparam logic [2:0] TR_WORD               = 3'd2;
  localparam logic [2:0] TR_BYTE_UNSIGNED      = 3'd3;
  localparam logic [2:0] TR_HALF_WORD_UNSIGNED = 3'd4;
  localparam logic [2:0] TR_NO_TRUNC           = 3'd5;

  function automatic logic [2:0] size_of(input logic [2:0] code);
    case (code)
      TR_BYTE, TR_BYTE_UNSIGNED:           size_of = 3'd1;
      TR_HALF_WORD, TR_HALF_WORD_UNSIGNED: size_of = 3'd2;
      default:                             size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] code);
    case (size_of(code))
      3'd1:    mask_of = 4'b0001;
      3'd2:    mask_of = 4'b0011;
      default: mask_of = 4'b1111;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] raw_q, raw_d;
  logic [2:0]      trunc_q, trunc_d;
  logic            write_q, write_d;
  logic            cross_q, cross_d;
  logic            fault_q, fault_d;

  logic            req_cross;
  logic [1:0]      off;
  logic [5:0]      sh_lo, sh_hi;
  logic [3:0]      mask, be_lo, be_hi;
  logic [XLEN-1:0] word_addr;
  logic [XLEN-1:0] load_ext;

  logic            stall_c, done_c, valid_c, write_c;
  logic [XLEN-1:0] addr_c, wdata_c;
  logic [3:0]      be_c;

  assign req_cross = ({1'b0, Addr[1:0]} + size_of(TruncSrc)) > 3'd4;

  // Lane shifts: sh_lo moves the low part up to the offset, sh_hi brings the
  // bytes that spilled past the word boundary into the second word.
  assign off       = addr_q[1:0];
  assign sh_lo     = {1'b0, off, 3'b000};
  assign sh_hi     = {(3'd4 - {1'b0, off}), 3'b000};
  assign mask      = mask_of(trunc_q);
  assign be_lo     = mask << off;
  assign be_hi     = mask >> (3'd4 - {1'b0, off});
  assign word_addr = {addr_q[XLEN-1:2], 2'b00};

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    raw_d   = raw_q;
    trunc_d = trunc_q;
    write_d = write_q;
    cross_d = cross_q;
    fault_d = fault_q;
    stall_c = 1'b0;
    done_c  = 1'b0;
    valid_c = 1'b0;
    write_c = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    be_c    = '0;

    case (state_q)
      ST_IDLE: begin
        if (MemReq) begin
          stall_c = 1'b1;
          addr_d  = Addr;
          wdata_d = WriteData;
          trunc_d = TruncSrc;
          write_d = MemWrite;
          cross_d = req_cross;
          fault_d = req_cross && !SPLIT_MISALIGNED;
          raw_d   = '0;
          state_d = (req_cross && !SPLIT_MISALIGNED) ? ST_RESP : ST_ACCESS0;
        end
      end
      ST_ACCESS0: begin
        stall_c = 1'b1;
        valid_c = 1'b1;
        write_c = write_q;
        addr_c  = word_addr;
        be_c    = be_lo;
        wdata_c = wdata_q << sh_lo;
        if (BusReady) begin
          raw_d   = BusRData >> sh_lo;
          state_d = cross_q ? ST_ACCESS1 : ST_RESP;
        end
      end
      ST_ACCESS1: begin
        stall_c = 1'b1;
        valid_c = 1'b1;
        write_c = write_q;
        addr_c  = {addr_q[XLEN-1:2] + 1'b1, 2'b00};
        be_c    = be_hi;
        wdata_c = wdata_q >> sh_hi;
        if (BusReady) begin
          raw_d   = raw_q | (BusRData << sh_hi);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: request/datapath registers carry no reset; they are always loaded in
  // IDLE before any state that reads them.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    raw_q   <= raw_d;
    trunc_q <= trunc_d;
    write_q <= write_d;
    cross_q <= cross_d;
    fault_q <= fault_d;
  end

  always_comb begin
    load_ext = raw_q;
    case (trunc_q)
      TR_BYTE:               load_ext = {{(XLEN-8){raw_q[7]}}, raw_q[7:0]};
      TR_HALF_WORD:          load_ext = {{(XLEN-16){raw_q[15]}}, raw_q[15:0]};
      TR_BYTE_UNSIGNED:      load_ext = {{(XLEN-8){1'b0}}, raw_q[7:0]};
      TR_HALF_WORD_UNSIGNED: load_ext = {{(XLEN-16){1'b0}}, raw_q[15:0]};
      TR_WORD, TR_NO_TRUNC:  load_ext = raw_q;
      default:               load_ext = raw_q;
    endcase
  end

  // Reset overrides everything visible to the pipeline and the bus at once.
  assign Stall         = !reset && stall_c;
  assign Done          = !reset && done_c;
  assign MisalignFault = Done && fault_q;
  assign ReadData      = (Done && !write_q && !fault_q) ? load_ext : '0;
  assign BusValid      = !reset && valid_c;
  assign BusWrite      = write_c;
  assign BusAddr       = addr_c;
  assign BusByteEn     = be_c;
  assign BusWData      = wdata_c;

endmodule

// File: tb/tb_data_memory_access_controller.sv
// Directed bench for data_memory_access_controller: aligned, sub-word, split,
// wait-state, reset-abort and fault-mode accesses.
module tb_data_memory_access_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, MemWrite;
  logic [2:0]  TruncSrc;
  logic [31:0] Addr, WriteData;
  logic        Stall, Done, MisalignFault, BusValid, BusReady, BusWrite;
  logic [31:0] ReadData, BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;

  logic        nf_MemReq, nf_MemWrite;
  logic [2:0]  nf_TruncSrc;
  logic [31:0] nf_Addr, nf_WriteData;
  logic        nf_Stall, nf_Done, nf_MisalignFault, nf_BusValid, nf_BusReady, nf_BusWrite;
  logic [31:0] nf_ReadData, nf_BusAddr, nf_BusWData, nf_BusRData;
  logic [3:0]  nf_BusByteEn;

  logic [31:0] mem [logic [31:0]];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_access_controller #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
    .TruncSrc(TruncSrc), .Addr(Addr), .WriteData(WriteData), .Stall(Stall),
    .Done(Done), .ReadData(ReadData), .MisalignFault(MisalignFault),
    .BusValid(BusValid), .BusReady(BusReady), .BusWrite(BusWrite),
    .BusAddr(BusAddr), .BusByteEn(BusByteEn), .BusWData(BusWData),
    .BusRData(BusRData)
  );

  data_memory_access_controller #(.XLEN(32), .SPLIT_MISALIGNED(1'b0)) dut_nf (
    .clk(clk), .reset(reset), .MemReq(nf_MemReq), .MemWrite(nf_MemWrite),
    .TruncSrc(nf_TruncSrc), .Addr(nf_Addr), .WriteData(nf_WriteData),
    .Stall(nf_Stall), .Done(nf_Done), .ReadData(nf_ReadData),
    .MisalignFault(nf_MisalignFault), .BusValid(nf_BusValid),
    .BusReady(nf_BusReady), .BusWrite(nf_BusWrite), .BusAddr(nf_BusAddr),
    .BusByteEn(nf_BusByteEn), .BusWData(nf_BusWData), .BusRData(nf_BusRData)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access on the split-enabled DUT; the bus responder answers from mem[]
  // after `waits` not-ready cycles per transfer and checks every bus cycle.
  task automatic do_access(input string tag, input logic wr, input logic [2:0] tr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input int ntx,
                           input logic [31:0] ea0, input logic [3:0] eb0, input logic [31:0] ew0,
                           input logic [31:0] ea1, input logic [3:0] eb1, input logic [31:0] ew1,
                           input logic [31:0] erd, input int edone);
    int tx   = 0;
    int wcnt = 0;
    int cyc  = 0;
    bit done = 1'b0;
    MemReq = 1'b1; MemWrite = wr; TruncSrc = tr; Addr = addr; WriteData = wd;
    while (!done && cyc < 40) begin
      #1;
      BusReady = 1'b0;
      if (BusValid) begin
        BusRData = mem.exists(BusAddr) ? mem[BusAddr] : 32'h0;
        BusReady = (wcnt == waits);
      end
      #1;
      check({tag, " stall"}, {31'b0, Stall}, {31'b0, (cyc < edone)});
      if (BusValid) begin
        check({tag, " tx_in_range"}, {31'b0, (tx < ntx)}, 32'd1);
        check({tag, " bus_addr"}, BusAddr, (tx == 0) ? ea0 : ea1);
        check({tag, " bus_be"}, {28'b0, BusByteEn}, {28'b0, (tx == 0) ? eb0 : eb1});
        check({tag, " bus_write"}, {31'b0, BusWrite}, {31'b0, wr});
        if (wr) check({tag, " bus_wdata"}, BusWData, (tx == 0) ? ew0 : ew1);
        if (BusReady) begin
          tx++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (Done) begin
        check({tag, " done_cycle"}, cyc, edone);
        check({tag, " rdata"}, ReadData, erd);
        check({tag, " fault"}, {31'b0, MisalignFault}, 32'd0);
        done   = 1'b1;
        MemReq = 1'b0;
      end
      next_cycle();
      cyc++;
    end
    BusReady = 1'b0;
    MemReq   = 1'b0;
    check({tag, " done_seen"}, {31'b0, done}, 32'd1);
    check({tag, " tx_count"}, tx, ntx);
  endtask

  initial begin
    reset = 1'b1;
    MemReq = 1'b1; MemWrite = 1'b0; TruncSrc = 3'd2; Addr = 32'h100; WriteData = '0;
    BusReady = 1'b0; BusRData = '0;
    nf_MemReq = 1'b1; nf_MemWrite = 1'b0; nf_TruncSrc = 3'd2; nf_Addr = 32'h100;
    nf_WriteData = '0; nf_BusReady = 1'b1; nf_BusRData = 32'h80112233;

    // Reset holds Stall low even with a pending request.
    next_cycle();
    #1;
    check("rst stall", {31'b0, Stall}, 32'd0);
    check("rst valid", {31'b0, BusValid}, 32'd0);
    check("rst done", {31'b0, Done}, 32'd0);
    check("rst rdata", ReadData, 32'd0);
    check("rst nf_stall", {31'b0, nf_Stall}, 32'd0);
    MemReq = 1'b0; nf_MemReq = 1'b0;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    #1;
    check("idle stall", {31'b0, Stall}, 32'd0);
    check("idle done", {31'b0, Done}, 32'd0);
    check("idle valid", {31'b0, BusValid}, 32'd0);
    next_cycle();

    mem[32'h100] = 32'hDEADBEEF;
    do_access("lw_aligned", 1'b0, 3'd2, 32'h100, 32'h0, 0, 1,
              32'h100, 4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 2);

    mem[32'h100] = 32'h80112233;
    do_access("lb_103", 1'b0, 3'd0, 32'h103, 32'h0, 0, 1,
              32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 2);
    do_access("lbu_103", 1'b0, 3'd3, 32'h103, 32'h0, 0, 1,
              32'h100, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00000080, 2);
    do_access("lh_102", 1'b0, 3'd1, 32'h102, 32'h0, 0, 1,
              32'h100, 4'b1100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'hFFFF8011, 2);
    do_access("lhu_102", 1'b0, 3'd4, 32'h102, 32'h0, 0, 1,
              32'h100, 4'b1100, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h00008011, 2);

    do_access("sh_102", 1'b1, 3'd1, 32'h102, 32'h1234ABCD, 0, 1,
              32'h100, 4'b1100, 32'hABCD0000, 32'h0, 4'b0000, 32'h0, 32'h0, 2);
    do_access("sb_101", 1'b1, 3'd0, 32'h101, 32'h00000055, 0, 1,
              32'h100, 4'b0010, 32'h00005500, 32'h0, 4'b0000, 32'h0, 32'h0, 2);

    mem[32'h100] = 32'h44332211;
    mem[32'h104] = 32'h88776655;
    do_access("lw_101_split", 1'b0, 3'd2, 32'h101, 32'h0, 0, 2,
              32'h100, 4'b1110, 32'h0, 32'h104, 4'b0001, 32'h0, 32'h55443322, 3);
    do_access("lhu_103_split", 1'b0, 3'd4, 32'h103, 32'h0, 0, 2,
              32'h100, 4'b1000, 32'h0, 32'h104, 4'b0001, 32'h0, 32'h00005544, 3);

    do_access("sw_103_wait", 1'b1, 3'd2, 32'h103, 32'hA1B2C3D4, 3, 2,
              32'h100, 4'b1000, 32'hD4000000, 32'h104, 4'b0111, 32'h00A1B2C3, 32'h0, 9);

    // Reset while the second half of a split load is waiting.
    MemReq = 1'b1; MemWrite = 1'b0; TruncSrc = 3'd2; Addr = 32'h101; WriteData = '0;
    #2;
    check("abort c0 stall", {31'b0, Stall}, 32'd1);
    next_cycle();
    #1;
    BusReady = 1'b1; BusRData = mem[32'h100];
    #1;
    check("abort c1 valid", {31'b0, BusValid}, 32'd1);
    next_cycle();
    BusReady = 1'b0;
    #2;
    check("abort c2 valid", {31'b0, BusValid}, 32'd1);
    check("abort c2 addr", BusAddr, 32'h104);
    reset = 1'b1;
    #1;
    check("abort rst stall", {31'b0, Stall}, 32'd0);
    check("abort rst valid", {31'b0, BusValid}, 32'd0);
    next_cycle();
    reset = 1'b0;
    MemReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("abort after valid", {31'b0, BusValid}, 32'd0);
      check("abort after done", {31'b0, Done}, 32'd0);
      check("abort after stall", {31'b0, Stall}, 32'd0);
      next_cycle();
    end

    // Split disabled: crossing access faults without touching the bus.
    nf_MemReq = 1'b1; nf_MemWrite = 1'b0; nf_TruncSrc = 3'd1; nf_Addr = 32'h103;
    #2;
    check("nf_lh c0 stall", {31'b0, nf_Stall}, 32'd1);
    check("nf_lh c0 valid", {31'b0, nf_BusValid}, 32'd0);
    next_cycle();
    #1;
    check("nf_lh c1 done", {31'b0, nf_Done}, 32'd1);
    check("nf_lh c1 fault", {31'b0, nf_MisalignFault}, 32'd1);
    check("nf_lh c1 rdata", nf_ReadData, 32'd0);
    check("nf_lh c1 stall", {31'b0, nf_Stall}, 32'd0);
    check("nf_lh c1 valid", {31'b0, nf_BusValid}, 32'd0);
    nf_MemReq = 1'b0;
    next_cycle();
    #1;
    check("nf_lh c2 done", {31'b0, nf_Done}, 32'd0);
    check("nf_lh c2 valid", {31'b0, nf_BusValid}, 32'd0);

    // Split disabled: a non-crossing load still goes to the bus normally.
    nf_MemReq = 1'b1; nf_TruncSrc = 3'd0; nf_Addr = 32'h101;
    next_cycle();
    #1;
    check("nf_lb c1 valid", {31'b0, nf_BusValid}, 32'd1);
    check("nf_lb c1 be", {28'b0, nf_BusByteEn}, 32'h2);
    check("nf_lb c1 addr", nf_BusAddr, 32'h100);
    next_cycle();
    #1;
    check("nf_lb c2 done", {31'b0, nf_Done}, 32'd1);
    check("nf_lb c2 rdata", nf_ReadData, 32'h00000022);
    check("nf_lb c2 fault", {31'b0, nf_MisalignFault}, 32'd0);
    nf_MemReq = 1'b0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
